// File: rtl/ctrl_pipe_hazard.sv
// Control-side pipeline registers (ID/EX, EX/MEM, MEM/WB) for a 5-stage core.
// Produces load-use stalls, branch flushes, EX forwarding selects and a retire count.
module ctrl_pipe_hazard #(
    parameter int CNT_W  = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_reg_write,
    input  logic              id_result_src,
    input  logic              id_mem_write,
    input  logic              id_branch,
    input  logic              id_alu_src,
    input  logic [2:0]        id_alu_control,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_zero,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              pc_src,
    output logic              ex_reg_write,
    output logic              ex_mem_write,
    output logic              ex_alu_src,
    output logic              ex_result_src,
    output logic [2:0]        ex_alu_control,
    output logic              mem_reg_write,
    output logic              mem_mem_write,
    output logic              mem_result_src,
    output logic              wb_reg_write,
    output logic              wb_result_src,
    output logic [REG_AW-1:0] wb_rd,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  instret
);

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              result_src;
        logic              mem_write;
        logic              branch;
        logic              alu_src;
        logic [2:0]        alu_control;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
    } ex_stage_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              result_src;
        logic              mem_write;
        logic [REG_AW-1:0] rd;
    } mem_stage_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              result_src;
        logic [REG_AW-1:0] rd;
    } wb_stage_t;

    ex_stage_t        ex_q,  ex_d;
    mem_stage_t       mem_q, mem_d;
    wb_stage_t        wb_q,  wb_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             load_use;
    logic             taken;

    // MEM beats WB so the youngest producer wins; x0 is hardwired and never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                           input mem_stage_t m,
                                           input wb_stage_t w);
        if (m.valid && m.reg_write && (m.rd != '0) && (m.rd == rs))
            return 2'b10;
        else if (w.valid && w.reg_write && (w.rd != '0) && (w.rd == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        taken    = ex_q.valid & ex_q.branch & ex_zero;
        load_use = ex_q.valid & ex_q.result_src & ex_q.reg_write & (ex_q.rd != '0)
                 & id_valid & ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));
    end

    // NOTE: every field gets a default before the conditional updates, so no latch is inferred.
    always_comb begin
        ex_d = '0;
        if (!(load_use || taken)) begin
            ex_d.valid       = id_valid;
            ex_d.reg_write   = id_reg_write;
            ex_d.result_src  = id_result_src;
            ex_d.mem_write   = id_mem_write;
            ex_d.branch      = id_branch;
            ex_d.alu_src     = id_alu_src;
            ex_d.alu_control = id_alu_control;
            ex_d.rs1         = id_rs1;
            ex_d.rs2         = id_rs2;
            ex_d.rd          = id_rd;
        end

        mem_d.valid      = ex_q.valid;
        mem_d.reg_write  = ex_q.reg_write;
        mem_d.result_src = ex_q.result_src;
        mem_d.mem_write  = ex_q.mem_write;
        mem_d.rd         = ex_q.rd;

        wb_d.valid      = mem_q.valid;
        wb_d.reg_write  = mem_q.reg_write;
        wb_d.result_src = mem_q.result_src;
        wb_d.rd         = mem_q.rd;

        instret_d = instret_q;
        if (wb_q.valid)
            instret_d = instret_q + CNT_W'(1);
    end

    // NOTE: state registers take non-blocking assignments so all stages shift on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            instret_q <= '0;
        end else begin
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
            instret_q <= instret_d;
        end
    end

    // A taken branch squashes the dependent instruction anyway, so it overrides the stall.
    assign stall_f        = load_use & ~taken;
    assign stall_d        = load_use & ~taken;
    assign flush_d        = taken;
    assign pc_src         = taken;
    assign ex_reg_write   = ex_q.reg_write;
    assign ex_mem_write   = ex_q.mem_write;
    assign ex_alu_src     = ex_q.alu_src;
    assign ex_result_src  = ex_q.result_src;
    assign ex_alu_control = ex_q.alu_control;
    assign mem_reg_write  = mem_q.reg_write;
    assign mem_mem_write  = mem_q.mem_write;
    assign mem_result_src = mem_q.result_src;
    assign wb_reg_write   = wb_q.reg_write;
    assign wb_result_src  = wb_q.result_src;
    assign wb_rd          = wb_q.rd;
    assign fwd_a          = fwd_sel(ex_q.rs1, mem_q, wb_q);
    assign fwd_b          = fwd_sel(ex_q.rs2, mem_q, wb_q);
    assign instret        = instret_q;

endmodule
